jtag_tap_multi_dr: RTL and testbench

JTAG_TAP_MULTI_DR -- requirements
Module: jtag_tap_multi_dr

---
 rtl/jtag_tap_multi_dr.sv | 159 +++++++++++++++
 tb/tb_jtag_tap_multi_dr.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/jtag_tap_multi_dr.sv
// rtl/jtag_tap_multi_dr.sv - IEEE 1149.1 TAP with IDCODE, BYPASS and N user data registers
//
// Ports:
//   tck           test clock, the only clock in the block
//   trst          asynchronous active-high reset
//   tms, tdi      mode select and serial data in, sampled on rising tck
//   tdo, tdo_en   serial data out and its valid flag, registered on falling tck
//   user_capture  parallel capture values, register k at [k*USER_WIDTH +: USER_WIDTH]
//   user_update   parallel update outputs, same slicing
//   user_strobe   one-tck pulse per user register when its update occurs
module jtag_tap_multi_dr #(
    parameter int          IR_WIDTH   = 4,
    parameter logic [31:0] IDCODE     = 32'h0000_0001,
    parameter int          N_USER     = 2,
    parameter int          USER_WIDTH = 8
) (
    input  logic                         tck,
    input  logic                         trst,
    input  logic                         tms,
    input  logic                         tdi,
    output logic                         tdo,
    output logic                         tdo_en,
    input  logic [N_USER*USER_WIDTH-1:0] user_capture,
    output logic [N_USER*USER_WIDTH-1:0] user_update,
    output logic [N_USER-1:0]            user_strobe
);

    typedef enum logic [3:0] {
        TLR, RTI,
        SEL_DR, CAP_DR, SH_DR, EX1_DR, PAU_DR, EX2_DR, UPD_DR,
        SEL_IR, CAP_IR, SH_IR, EX1_IR, PAU_IR, EX2_IR, UPD_IR
    } tap_state_t;

    localparam logic [IR_WIDTH-1:0] IR_IDCODE = IR_WIDTH'(1);

    tap_state_t             state_q, state_d;
    logic [IR_WIDTH-1:0]    ir_q;
    logic [IR_WIDTH-1:0]    ir_sr_q;
    logic                   byp_q;
    logic [31:0]            id_sr_q;
    logic [USER_WIDTH-1:0]  usr_sr_q;

    logic [N_USER-1:0]      user_hit;
    logic                   sel_user;
    logic                   sel_idcode;
    logic [USER_WIDTH-1:0]  user_cap_sel;
    logic                   dr_lsb;
    logic [USER_WIDTH:0]    usr_shift;
    logic [IR_WIDTH:0]      ir_shift;

    always_comb begin
        state_d = state_q;
        case (state_q)
            TLR:    state_d = tms ? TLR    : RTI;
            RTI:    state_d = tms ? SEL_DR : RTI;
            SEL_DR: state_d = tms ? SEL_IR : CAP_DR;
            CAP_DR: state_d = tms ? EX1_DR : SH_DR;
            SH_DR:  state_d = tms ? EX1_DR : SH_DR;
            EX1_DR: state_d = tms ? UPD_DR : PAU_DR;
            PAU_DR: state_d = tms ? EX2_DR : PAU_DR;
            EX2_DR: state_d = tms ? UPD_DR : SH_DR;
            UPD_DR: state_d = tms ? SEL_DR : RTI;
            SEL_IR: state_d = tms ? TLR    : CAP_IR;
            CAP_IR: state_d = tms ? EX1_IR : SH_IR;
            SH_IR:  state_d = tms ? EX1_IR : SH_IR;
            EX1_IR: state_d = tms ? UPD_IR : PAU_IR;
            PAU_IR: state_d = tms ? EX2_IR : PAU_IR;
            EX2_IR: state_d = tms ? UPD_IR : SH_IR;
            UPD_IR: state_d = tms ? SEL_DR : RTI;
            default: state_d = TLR;
        endcase
    end

    // User codes start at 2 and stay below all-ones, so any code that hits
    // neither IDCODE nor a user register falls through to BYPASS.
    always_comb begin
        user_hit     = '0;
        user_cap_sel = '0;
        for (int k = 0; k < N_USER; k++) begin
            user_hit[k]  = (ir_q == IR_WIDTH'(2 + k));
            user_cap_sel = user_cap_sel |
                           (user_hit[k] ? user_capture[k*USER_WIDTH +: USER_WIDTH] : '0);
        end
        sel_user   = |user_hit;
        sel_idcode = (ir_q == IR_IDCODE);
        dr_lsb     = sel_user ? usr_sr_q[0] : (sel_idcode ? id_sr_q[0] : byp_q);
        // Widened concatenations keep the shift legal even for 1-bit registers.
        usr_shift  = {tdi, usr_sr_q};
        ir_shift   = {tdi, ir_sr_q};
    end

    always_ff @(posedge tck or posedge trst) begin
        if (trst) begin
            state_q     <= TLR;
            ir_q        <= IR_IDCODE;
            ir_sr_q     <= '0;
            byp_q       <= 1'b0;
            id_sr_q     <= '0;
            usr_sr_q    <= '0;
            user_update <= '0;
            user_strobe <= '0;
        end else begin
            state_q     <= state_d;
            user_strobe <= '0;
            case (state_q)
                CAP_IR: ir_sr_q <= IR_WIDTH'(1);
                SH_IR:  ir_sr_q <= ir_shift[IR_WIDTH:1];
                UPD_IR: ir_q    <= ir_sr_q;
                CAP_DR: begin
                    if (sel_user)        usr_sr_q <= user_cap_sel;
                    else if (sel_idcode) id_sr_q  <= IDCODE;
                    else                 byp_q    <= 1'b0;
                end
                SH_DR: begin
                    if (sel_user)        usr_sr_q <= usr_shift[USER_WIDTH:1];
                    else if (sel_idcode) id_sr_q  <= {tdi, id_sr_q[31:1]};
                    else                 byp_q    <= tdi;
                end
                UPD_DR: begin
                    // IDCODE and BYPASS leave every output untouched.
                    for (int k = 0; k < N_USER; k++) begin
                        if (user_hit[k]) begin
                            user_update[k*USER_WIDTH +: USER_WIDTH] <= usr_sr_q;
                        end
                    end
                    user_strobe <= user_hit;
                end
                default: ;
            endcase
            // Any entry into (or stay in) Test-Logic-Reset reselects IDCODE.
            if (state_d == TLR) begin
                ir_q <= IR_IDCODE;
            end
        end
    end

    always_ff @(negedge tck or posedge trst) begin
        if (trst) begin
            tdo    <= 1'b0;
            tdo_en <= 1'b0;
        end else begin
            case (state_q)
                SH_IR: begin
                    tdo    <= ir_sr_q[0];
                    tdo_en <= 1'b1;
                end
                SH_DR: begin
                    tdo    <= dr_lsb;
                    tdo_en <= 1'b1;
                end
                default: begin
                    tdo    <= 1'b0;
                    tdo_en <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jtag_tap_multi_dr.sv
// tb/tb_jtag_tap_multi_dr.sv - directed self-checking bench for jtag_tap_multi_dr
module tb_jtag_tap_multi_dr;

    logic        tck = 1'b0;
    logic        trst = 1'b1;
    logic        tms = 1'b1;
    logic        tdi = 1'b0;
    logic        tdo;
    logic        tdo_en;
    logic [15:0] user_capture = 16'h0000;
    logic [15:0] user_update;
    logic [1:0]  user_strobe;

    int checks = 0;
    int failures = 0;

    logic [63:0] dout;
    logic [63:0] dout2;

    jtag_tap_multi_dr dut (
        .tck          (tck),
        .trst         (trst),
        .tms          (tms),
        .tdi          (tdi),
        .tdo          (tdo),
        .tdo_en       (tdo_en),
        .user_capture (user_capture),
        .user_update  (user_update),
        .user_strobe  (user_strobe)
    );

    always #5 tck = ~tck;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Inputs change just after the falling edge; outputs are sampled there too.
    task automatic step(input logic m, input logic d);
        tms = m;
        tdi = d;
        @(posedge tck);
        @(negedge tck);
        #1;
    endtask

    // Reads tdo before each shift edge; the last edge leaves the shift state.
    task automatic shift_bits(input int n, input logic [63:0] din, output logic [63:0] dq);
        dq = '0;
        for (int i = 0; i < n; i++) begin
            dq[i] = tdo;
            step(i == n - 1, din[i]);
        end
    endtask

    task automatic load_ir(input logic [3:0] v);
        logic [63:0] o;
        step(1, 0); step(1, 0); step(0, 0); step(0, 0);
        shift_bits(4, {60'd0, v}, o);
        chk("ir_capture", o, 64'h1);
        step(1, 0); step(0, 0);
    endtask

    task automatic dr_enter();
        step(1, 0); step(0, 0); step(0, 0);
    endtask

    initial begin
        #1;
        chk("rst_tdo", {63'd0, tdo}, 64'd0);
        chk("rst_tdo_en", {63'd0, tdo_en}, 64'd0);
        chk("rst_update", {48'd0, user_update}, 64'd0);
        chk("rst_strobe", {62'd0, user_strobe}, 64'd0);
        @(negedge tck); #1;
        trst = 1'b0;
        for (int i = 0; i < 5; i++) step(1, 0);
        chk("tlr_tdo_en", {63'd0, tdo_en}, 64'd0);
        chk("tlr_update", {48'd0, user_update}, 64'd0);
        step(0, 0);

        // IDCODE after reset, with 8 extra bits passing straight through
        dr_enter();
        chk("idc_tdo_en", {63'd0, tdo_en}, 64'd1);
        shift_bits(40, 64'h0000_00C3_0000_00A7, dout);
        chk("idc_shift", dout, 64'h0000_00A7_0000_0001);
        chk("ex1_tdo_en", {63'd0, tdo_en}, 64'd0);
        step(1, 0); step(0, 0);
        chk("idc_no_strobe", {62'd0, user_strobe}, 64'd0);
        chk("idc_no_update", {48'd0, user_update}, 64'd0);

        // BYPASS: tdi 1,0,1,1 appears one cycle late after a captured 0
        load_ir(4'b1111);
        dr_enter();
        shift_bits(5, 64'b01101, dout);
        chk("byp_shift", dout, 64'b11010);
        step(1, 0); step(0, 0);
        chk("byp_no_update", {48'd0, user_update}, 64'd0);

        // USER_0
        user_capture = 16'h773C;
        load_ir(4'b0010);
        dr_enter();
        shift_bits(8, 64'hA5, dout);
        chk("u0_capture", dout, 64'h3C);
        step(1, 0);
        chk("u0_strobe_early", {62'd0, user_strobe}, 64'd0);
        step(0, 0);
        chk("u0_update", {48'd0, user_update}, 64'h00A5);
        chk("u0_strobe", {62'd0, user_strobe}, 64'b01);
        step(0, 0);
        chk("u0_strobe_end", {62'd0, user_strobe}, 64'd0);

        // USER_1 with a pause in the middle of the shift
        load_ir(4'b0011);
        dr_enter();
        shift_bits(4, 64'hC, dout);
        step(0, 0); step(0, 0);
        chk("pause_tdo_en", {63'd0, tdo_en}, 64'd0);
        step(1, 0); step(0, 0);
        shift_bits(4, 64'h5, dout2);
        chk("u1_capture", {dout2[3:0], dout[3:0]}, 64'h77);
        step(1, 0); step(0, 0);
        chk("u1_update", {48'd0, user_update}, 64'h5CA5);
        chk("u1_strobe", {62'd0, user_strobe}, 64'b10);

        // Unused code behaves as BYPASS and changes nothing
        load_ir(4'b0110);
        dr_enter();
        shift_bits(3, 64'b011, dout);
        chk("unused_shift", dout, 64'b110);
        step(1, 0); step(0, 0);
        chk("unused_update", {48'd0, user_update}, 64'h5CA5);
        chk("unused_strobe", {62'd0, user_strobe}, 64'd0);

        // Entering TLR via tms reselects IDCODE and holds user_update
        load_ir(4'b0010);
        for (int i = 0; i < 5; i++) step(1, 0);
        step(0, 0);
        dr_enter();
        shift_bits(32, 64'hFFFF_FFFF, dout);
        chk("tlr_idcode", dout, 64'h1);
        step(1, 0); step(0, 0);
        chk("tlr_held_update", {48'd0, user_update}, 64'h5CA5);

        // trst during a USER_1 shift discards it
        load_ir(4'b0011);
        dr_enter();
        step(0, 1); step(0, 1); step(0, 0);
        chk("mid_tdo_en", {63'd0, tdo_en}, 64'd1);
        trst = 1'b1;
        #1;
        chk("trst_update", {48'd0, user_update}, 64'd0);
        chk("trst_strobe", {62'd0, user_strobe}, 64'd0);
        chk("trst_tdo_en", {63'd0, tdo_en}, 64'd0);
        @(negedge tck); @(negedge tck); #1;
        trst = 1'b0;
        step(0, 0);
        dr_enter();
        shift_bits(32, 64'h0, dout);
        chk("post_trst_idcode", dout, 64'h1);
        step(1, 0); step(0, 0);
        chk("post_trst_update", {48'd0, user_update}, 64'd0);
        chk("post_trst_strobe", {62'd0, user_strobe}, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
